// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: memory-wait FSM state
// encoding, default register-index width and the x0 register index.
package hazard_pkg;

    // Memory-wait FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Default register-index width (32 architectural registers)
    localparam int unsigned REG_AW_DEF = 5;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Memory-wait sequencer: holds the pipeline for DMEM_LAT cycles per data-memory
// access, then gives one release cycle in which the MEM instruction advances
// and mem_req is ignored. DMEM_LAT = 0 means single-cycle memory (never stalls).
module hazard_mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned DMEM_LAT = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_req,
    output logic mstall
);

    localparam bit          HAS_WAIT     = (DMEM_LAT != 0);
    localparam int unsigned CNT_INIT_INT = (DMEM_LAT > 0) ? DMEM_LAT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_INT);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state, counter and stall decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mstall  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req && HAS_WAIT) begin
                    mstall  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    mstall = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    // Release cycle: MEM instruction advances, new requests wait
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers, synchronous reset aborts any wait
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives kill/stall for IF/ID, ID/EX, EX/MEM,
// MEM/WB and the PC hold. Priority: memory wait > EX redirect > load-use.
// Outputs are combinational from FSM state and current inputs.
// Optional HAZARD_PERF_CNT_EN adds perf_stall_cycles / perf_flushes counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned DMEM_LAT = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              mem_req,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_kill,
    output logic              idex_stall,
    output logic              idex_kill,
    output logic              exmem_stall,
    output logic              exmem_kill,
    output logic              memwb_kill,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes,
`endif
    output logic              mem_wait
);

    logic mstall;
    logic load_use;

    hazard_mem_wait_fsm #(
        .DMEM_LAT (DMEM_LAT),
        .CNT_W    (CNT_W)
    ) u_mem_wait_fsm (
        .clock    (clock),
        .reset    (reset),
        .mem_req  (mem_req),
        .mstall   (mstall)
    );

    // Load-use: EX load writes a register the ID instruction reads (x0 excluded)
    always_comb begin
        load_use = ex_is_load && (ex_rd != REG_AW'(X0_IDX)) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Prioritised kill/stall decode; kill is never raised on a stalled register
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_kill   = 1'b0;
        idex_stall  = 1'b0;
        idex_kill   = 1'b0;
        exmem_stall = 1'b0;
        exmem_kill  = 1'b0;
        memwb_kill  = 1'b0;
        mem_wait    = 1'b0;
        if (reset) begin
            // Flush every pipeline register
            ifid_kill  = 1'b1;
            idex_kill  = 1'b1;
            exmem_kill = 1'b1;
            memwb_kill = 1'b1;
        end else if (mstall) begin
            // Freeze IF..MEM, bubble into WB; redirect/load-use re-evaluate later
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_kill  = 1'b1;
            mem_wait    = 1'b1;
        end else if (ex_redirect) begin
            // PC loads target; younger wrong-path instructions are squashed
            ifid_kill = 1'b1;
            idex_kill = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_kill  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles_q, perf_flushes_q;

    // Performance counters, wrap modulo 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles_q <= '0;
            perf_flushes_q      <= '0;
        end else begin
            if (pc_stall) begin
                perf_stall_cycles_q <= perf_stall_cycles_q + 32'd1;
            end
            if (ex_redirect && !mstall) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_cycles_q;
    assign perf_flushes      = perf_flushes_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance with DMEM_LAT=2, one with
// DMEM_LAT=0, both fed the same stimulus. The driver pushes expected outputs
// from a cycle-age reference model; a monitor pops and compares at negedge.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_req;

    logic a_pc_stall, a_ifid_stall, a_ifid_kill, a_idex_stall, a_idex_kill;
    logic a_exmem_stall, a_exmem_kill, a_memwb_kill, a_mem_wait;
    logic z_pc_stall, z_ifid_stall, z_ifid_kill, z_idex_stall, z_idex_kill;
    logic z_exmem_stall, z_exmem_kill, z_memwb_kill, z_mem_wait;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] a_perf_stall, a_perf_flush, z_perf_stall, z_perf_flush;
`endif

    hazard_ctrl #(.REG_AW(AW), .DMEM_LAT(2), .CNT_W(2)) dut_a (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_kill(a_ifid_kill),
        .idex_stall(a_idex_stall), .idex_kill(a_idex_kill),
        .exmem_stall(a_exmem_stall), .exmem_kill(a_exmem_kill),
        .memwb_kill(a_memwb_kill),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(a_perf_stall), .perf_flushes(a_perf_flush),
`endif
        .mem_wait(a_mem_wait)
    );

    hazard_ctrl #(.REG_AW(AW), .DMEM_LAT(0), .CNT_W(2)) dut_z (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .pc_stall(z_pc_stall), .ifid_stall(z_ifid_stall), .ifid_kill(z_ifid_kill),
        .idex_stall(z_idex_stall), .idex_kill(z_idex_kill),
        .exmem_stall(z_exmem_stall), .exmem_kill(z_exmem_kill),
        .memwb_kill(z_memwb_kill),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(z_perf_stall), .perf_flushes(z_perf_flush),
`endif
        .mem_wait(z_mem_wait)
    );

    // Bit order: pc_stall ifid_stall ifid_kill idex_stall idex_kill
    //            exmem_stall exmem_kill memwb_kill mem_wait
    wire logic [8:0] a_out = {a_pc_stall, a_ifid_stall, a_ifid_kill, a_idex_stall,
                              a_idex_kill, a_exmem_stall, a_exmem_kill, a_memwb_kill,
                              a_mem_wait};
    wire logic [8:0] z_out = {z_pc_stall, z_ifid_stall, z_ifid_kill, z_idex_stall,
                              z_idex_kill, z_exmem_stall, z_exmem_kill, z_memwb_kill,
                              z_mem_wait};

    typedef struct {
        logic [8:0]  exp_a;
        logic [8:0]  exp_z;
        logic [31:0] exp_ps;
        logic [31:0] exp_pf;
        bit          perf_ok;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state: age = cycles since the current access began, -1 if none
    int          age_a = -1, age_z = -1;
    logic [31:0] ps_cnt = '0, pf_cnt = '0;
    bit          perf_known = 1'b0;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else passes++;
    endtask

    // An access stalls for `lat` cycles from its first cycle, then releases once
    task automatic access_step(input int lat, input bit rst, input bit req, input int age_in,
                               output bit mst, output int age_out);
        int a;
        mst = 1'b0;
        age_out = -1;
        if (!rst) begin
            a = age_in;
            if (a < 0 && req && lat > 0) a = 0;
            if (a >= 0) begin
                mst = (a < lat);
                age_out = (a == lat) ? -1 : a + 1;
            end
        end
    endtask

    function automatic logic [8:0] expect_out(input bit rst, input bit mst, input bit redir,
                                              input bit lu);
        if (rst)        return 9'b0_0_1_0_1_0_1_1_0;
        else if (mst)   return 9'b1_1_0_1_0_1_0_1_1;
        else if (redir) return 9'b0_0_1_0_1_0_0_0_0;
        else if (lu)    return 9'b1_1_0_0_1_0_0_0_0;
        else            return 9'b0;
    endfunction

    task automatic cyc(input bit rst, input bit ld, input int rd, input bit u1, input int r1,
                       input bit u2, input int r2, input bit redir, input bit req);
        exp_t e;
        bit   mst_a, mst_z, lu;
        @(posedge clock);
        #1;
        reset = rst; ex_is_load = ld; ex_rd = rd[AW-1:0];
        id_use_rs1 = u1; id_rs1 = r1[AW-1:0]; id_use_rs2 = u2; id_rs2 = r2[AW-1:0];
        ex_redirect = redir; mem_req = req;
        lu = ld && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        access_step(2, rst, req, age_a, mst_a, age_a);
        access_step(0, rst, req, age_z, mst_z, age_z);
        e.exp_a = expect_out(rst, mst_a, redir, lu);
        e.exp_z = expect_out(rst, mst_z, redir, lu);
        e.exp_ps = ps_cnt;
        e.exp_pf = pf_cnt;
        e.perf_ok = perf_known;
        sb.push_back(e);
        if (rst) begin
            ps_cnt = '0; pf_cnt = '0; perf_known = 1'b1;
        end else begin
            if (e.exp_a[8]) ps_cnt = ps_cnt + 1;
            if (redir && !mst_a) pf_cnt = pf_cnt + 1;
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lat2_outputs", {23'd0, a_out}, {23'd0, e.exp_a});
                check("lat0_outputs", {23'd0, z_out}, {23'd0, e.exp_z});
`ifdef HAZARD_PERF_CNT_EN
                if (e.perf_ok) begin
                    check("perf_stall_cycles", a_perf_stall, e.exp_ps);
                    check("perf_flushes", a_perf_flush, e.exp_pf);
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ex_is_load = 0; ex_rd = '0; id_use_rs1 = 0; id_rs1 = '0;
        id_use_rs2 = 0; id_rs2 = '0; ex_redirect = 0; mem_req = 0;
        //     rst ld rd u1 r1 u2 r2 rdr req
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs1, then it clears
        cyc(0, 1, 5, 1, 5, 0, 0, 0, 0);
        cyc(0, 0, 5, 1, 5, 0, 0, 0, 0);
        // Load to x0: no hazard; rs2 match; unused-operand match
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 7, 0, 3, 1, 7, 0, 0);
        cyc(0, 1, 7, 0, 7, 0, 7, 0, 0);
        // Redirect beats load-use
        cyc(0, 1, 5, 1, 5, 0, 0, 1, 0);
        // Memory wait with mem_req held: stall, stall, release, new wait
        repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Memory wait plus redirect from IDLE: redirect deferred to release
        repeat (3) cyc(0, 1, 4, 1, 4, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-WAIT, then quiet
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic with small register range to provoke matches
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) == 0));
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
